// File: rtl/loader_pkg.sv
// Shared types and constants for the UART RAM loader and its receiver.
package loader_pkg;

    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic [2:0] {
        IDLE,
        CNT_H,
        CNT_L,
        WHI,
        WLO,
        FINISH
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver with 2-flop synchronizer and mid-bit sampling.
// Latency: byte_valid/frame_err pulse one cycle after the stop-bit sample.
// Backpressure: none; bytes are dropped if the consumer is not listening.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic       CLK_50,
    input  logic       resetN,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err,
    output logic       start_seen
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    rx_state_t     state, state_nxt;
    logic          rx_meta, rx_sync, rx_sync_d;
    logic [CW-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          byte_valid_nxt, frame_err_nxt, start_seen_nxt;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_sync_d  <= 1'b1;
            state      <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            start_seen <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_sync_d  <= rx_sync;
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
            start_seen <= start_seen_nxt;
        end
    end

    // The stop bit is judged at its centre and the receiver rearms at once,
    // so a start edge with no idle bits in between is still caught.
    always_comb begin
        state_nxt      = state;
        baud_cnt_nxt   = baud_cnt + CNT_ONE;
        bit_cnt_nxt    = bit_cnt;
        shift_nxt      = shift;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = 1'b0;
        start_seen_nxt = 1'b0;
        case (state)
            RX_IDLE: begin
                baud_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                if (rx_sync_d && !rx_sync) state_nxt = RX_START;
            end
            RX_START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_nxt = '0;
                    if (!rx_sync) begin
                        state_nxt      = RX_DATA;
                        start_seen_nxt = 1'b1;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nxt = '0;
                    shift_nxt    = {rx_sync, shift[7:1]};
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_cnt_nxt   = '0;
                    state_nxt      = RX_IDLE;
                    byte_valid_nxt = rx_sync;
                    frame_err_nxt  = !rx_sync;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/uart_ram_loader.sv
// Purpose: loads a counted, big-endian word image from UART into RAM.
// Latency: we/addr/wdata one cycle after the LO byte's byte_valid.
// Backpressure: none; RAM write port is assumed always ready.
module uart_ram_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 12,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic                  CLK_50,
    input  logic                  resetN,
    input  logic                  rx,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_error
);

    logic       byte_valid, frame_err, start_seen;
    logic [7:0] byte_data;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK_50     (CLK_50),
        .resetN     (resetN),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .start_seen (start_seen)
    );

    loader_state_t         state, state_nxt;
    logic [15:0]           cnt, cnt_nxt;
    logic [7:0]            hi, hi_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic                  we_nxt, busy_nxt, done_nxt, ferr_nxt;

    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            cnt         <= '0;
            hi          <= '0;
            addr        <= '0;
            wdata       <= '0;
            we          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hi          <= hi_nxt;
            addr        <= addr_nxt;
            wdata       <= wdata_nxt;
            we          <= we_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            frame_error <= ferr_nxt;
        end
    end

    // hi doubles as the CNT_H holding register before the count is latched.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        addr_nxt  = we ? addr + ADDR_WIDTH'(1) : addr;
        wdata_nxt = wdata;
        we_nxt    = 1'b0;
        busy_nxt  = busy;
        done_nxt  = done;
        ferr_nxt  = frame_error;
        case (state)
            IDLE: begin
                if (start_seen) begin
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    ferr_nxt  = 1'b0;
                    state_nxt = CNT_H;
                end
            end
            CNT_H: begin
                if (byte_valid) begin
                    hi_nxt    = byte_data;
                    state_nxt = CNT_L;
                end
            end
            CNT_L: begin
                if (byte_valid) begin
                    cnt_nxt   = {hi, byte_data};
                    addr_nxt  = '0;
                    state_nxt = ({hi, byte_data} == 16'd0) ? FINISH : WHI;
                end
            end
            WHI: begin
                if (byte_valid) begin
                    hi_nxt    = byte_data;
                    state_nxt = WLO;
                end
            end
            WLO: begin
                if (byte_valid) begin
                    wdata_nxt = DATA_WIDTH'({hi, byte_data});
                    we_nxt    = 1'b1;
                    cnt_nxt   = cnt - 16'd1;
                    state_nxt = (cnt == 16'd1) ? FINISH : WHI;
                end
            end
            FINISH: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (frame_err && state != IDLE) begin
            state_nxt = IDLE;
            we_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            ferr_nxt  = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Randomized UART load stimulus checked against an expected-write queue model.
module tb_uart_ram_loader;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic rx = 1'b1;

    logic        we_a, busy_a, done_a, ferr_a;
    logic [11:0] addr_a;
    logic [15:0] wdata_a;
    logic        we_w, busy_w, done_w, ferr_w;
    logic [1:0]  addr_w;
    logic [15:0] wdata_w;

    always #5 clk = ~clk;

    uart_ram_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .CLKS_PER_BIT(CPB)) dut_a (
        .CLK_50(clk), .resetN(resetN), .rx(rx), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .busy(busy_a), .done(done_a), .frame_error(ferr_a)
    );

    uart_ram_loader #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .CLKS_PER_BIT(CPB)) dut_w (
        .CLK_50(clk), .resetN(resetN), .rx(rx), .we(we_w), .addr(addr_w),
        .wdata(wdata_w), .busy(busy_w), .done(done_w), .frame_error(ferr_w)
    );

    int tests = 0;
    int fails = 0;

    // Model: every accepted word i lands at address i mod 2^ADDR_WIDTH.
    logic [31:0] q_a[$];
    logic [31:0] q_w[$];
    logic [31:0] log_a[$];
    logic [31:0] log_w[$];
    logic [15:0] wbuf[16];
    int          exp_n = 0;

    logic we_prev_a = 1'b0, we_prev_w = 1'b0, busy_prev_a = 1'b0, busy_prev_w = 1'b0;
    logic [31:0] ea, ew;

    always @(negedge clk) begin
        if (!resetN) begin
            we_prev_a <= 1'b0; we_prev_w <= 1'b0;
            busy_prev_a <= 1'b0; busy_prev_w <= 1'b0;
        end else begin
            if (we_a) begin
                tests++;
                log_a.push_back({4'b0, addr_a, wdata_a});
                if (q_a.size() == 0) begin
                    fails++;
                    $display("FAIL write_a: unexpected write addr=%0h wdata=%0h", addr_a, wdata_a);
                end else begin
                    ea = q_a.pop_front();
                    if ({4'b0, addr_a} !== ea[31:16] || wdata_a !== ea[15:0]) begin
                        fails++;
                        $display("FAIL write_a: got addr=%0h wdata=%0h, expected addr=%0h wdata=%0h",
                                 addr_a, wdata_a, ea[31:16], ea[15:0]);
                    end
                end
                tests++;
                if (we_prev_a) begin
                    fails++;
                    $display("FAIL we_a_consecutive: we high two cycles, expected single pulse");
                end
            end
            if (we_w) begin
                tests++;
                log_w.push_back({14'b0, addr_w, wdata_w});
                if (q_w.size() == 0) begin
                    fails++;
                    $display("FAIL write_w: unexpected write addr=%0h wdata=%0h", addr_w, wdata_w);
                end else begin
                    ew = q_w.pop_front();
                    if ({14'b0, addr_w} !== ew[31:16] || wdata_w !== ew[15:0]) begin
                        fails++;
                        $display("FAIL write_w: got addr=%0h wdata=%0h, expected addr=%0h wdata=%0h",
                                 addr_w, wdata_w, ew[31:16], ew[15:0]);
                    end
                end
            end
            if (busy_prev_a && !busy_a) begin
                tests++;
                if (!((ferr_a && !done_a) || (done_a && !ferr_a && (exp_n == 0 || we_prev_a)))) begin
                    fails++;
                    $display("FAIL busy_fall_a: done=%0b frame_error=%0b prev_we=%0b, expected done with fall after final we or frame_error",
                             done_a, ferr_a, we_prev_a);
                end
            end
            we_prev_a <= we_a; we_prev_w <= we_w;
            busy_prev_a <= busy_a; busy_prev_w <= busy_w;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic gap(input int gap_max);
        repeat ($urandom_range(gap_max, 0) * CPB) @(negedge clk);
    endtask

    task automatic run_load(input int n, input int gap_max);
        logic [15:0] cnt;
        cnt = 16'(n);
        exp_n = n;
        for (int i = 0; i < n; i++) begin
            q_a.push_back({16'(i % 4096), wbuf[i]});
            q_w.push_back({16'(i % 4), wbuf[i]});
        end
        send_byte(cnt[15:8], 1'b1);
        check("busy_after_cnt_h", {31'b0, busy_a}, 32'd1);
        gap(gap_max);
        send_byte(cnt[7:0], 1'b1);
        for (int i = 0; i < n; i++) begin
            gap(gap_max);
            send_byte(wbuf[i][15:8], 1'b1);
            gap(gap_max);
            send_byte(wbuf[i][7:0], 1'b1);
        end
        repeat (3 * CPB) @(negedge clk);
        check("load_busy", {31'b0, busy_a}, 32'd0);
        check("load_done", {31'b0, done_a}, 32'd1);
        check("load_frame_error", {31'b0, ferr_a}, 32'd0);
        check("load_pending_a", q_a.size(), 32'd0);
        check("load_pending_w", q_w.size(), 32'd0);
    endtask

    initial begin
        int base;
        logic saw_busy;
        repeat (3) @(negedge clk);
        check("rst_we", {31'b0, we_a}, 0);
        check("rst_addr", {20'b0, addr_a}, 0);
        check("rst_wdata", {16'b0, wdata_a}, 0);
        check("rst_busy", {31'b0, busy_a}, 0);
        check("rst_done", {31'b0, done_a}, 0);
        check("rst_frame_error", {31'b0, ferr_a}, 0);
        resetN = 1'b1;
        repeat (4 * CPB) @(negedge clk);

        // Basic load, back-to-back bytes.
        base = log_a.size();
        wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
        run_load(2, 0);
        check("basic_count", log_a.size() - base, 2);
        check("basic_w0", log_a[base], 32'h0000_1234);
        check("basic_w1", log_a[base+1], 32'h0001_ABCD);

        // Zero count.
        base = log_a.size();
        run_load(0, 1);
        check("zero_count_writes", log_a.size() - base, 0);

        // False start.
        base = log_a.size();
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 5 * CPB; i++) begin
            @(negedge clk);
            if (busy_a || busy_w) saw_busy = 1'b1;
        end
        check("false_start_busy", {31'b0, saw_busy}, 0);
        check("false_start_done_kept", {31'b0, done_a}, 1);
        check("false_start_writes", log_a.size() - base, 0);

        // Frame error on the HI byte of word 1.
        exp_n = 3;
        q_a.push_back({16'h0000, 16'h1111});
        q_w.push_back({16'h0000, 16'h1111});
        send_byte(8'h00, 1'b1); send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check("ferr_flag", {31'b0, ferr_a}, 1);
        check("ferr_busy", {31'b0, busy_a}, 0);
        check("ferr_done", {31'b0, done_a}, 0);
        check("ferr_pending", q_a.size(), 0);
        check("ferr_last_write", log_a[log_a.size()-1], 32'h0000_1111);
        wbuf[0] = 16'h55AA;
        run_load(1, 0);
        check("after_ferr_write", log_a[log_a.size()-1], 32'h0000_55AA);

        // Wrap-around on the 2-bit address instance.
        for (int i = 0; i < 5; i++) wbuf[i] = 16'(i + 1);
        run_load(5, 0);
        check("wrap_addr3", log_w[log_w.size()-2], 32'h0003_0004);
        check("wrap_last", log_w[log_w.size()-1], 32'h0000_0005);

        // Reset after the HI byte of word 0.
        base = log_a.size();
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h77, 1'b1);
        repeat (CPB) @(negedge clk);
        check("mid_busy_before_reset", {31'b0, busy_a}, 1);
        resetN = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy_a}, 0);
        check("mid_rst_done", {31'b0, done_a}, 0);
        check("mid_rst_frame_error", {31'b0, ferr_a}, 0);
        check("mid_rst_we", {31'b0, we_a}, 0);
        check("mid_rst_addr", {20'b0, addr_a}, 0);
        check("mid_rst_wdata", {16'b0, wdata_a}, 0);
        check("mid_rst_writes", log_a.size() - base, 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        wbuf[0] = 16'hBEEF; wbuf[1] = 16'h0102;
        run_load(2, 1);

        // Randomized loads with random inter-byte idle gaps.
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(6, 0);
            for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
            run_load(n, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
